// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
// Bundles the PLL-facing and system-facing signals of pll_lock_supervisor.
//
// Signals
//   pll_lock_i       PLL LOCK, asynchronous to clk
//   relock_req_i     single-cycle request to force a full re-lock sequence
//   pll_rst_o        drives the PLL RESET pin, active high
//   sys_rst_o        synchronous system reset for PLL-clocked logic, active high
//   ready_o          high only while the supervisor is in RUN
//   fault_o          sticky fault, retries exhausted
//   lock_loss_cnt_o  saturating count of lock losses seen in RUN
//
// Modports
//   master  the environment: drives lock/relock, observes the outputs
//   slave   the supervisor: observes lock/relock, drives the outputs
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if;
  logic       pll_lock_i;
  logic       relock_req_i;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       ready_o;
  logic       fault_o;
  logic [7:0] lock_loss_cnt_o;

  modport master (
    output pll_lock_i,
    output relock_req_i,
    input  pll_rst_o,
    input  sys_rst_o,
    input  ready_o,
    input  fault_o,
    input  lock_loss_cnt_o
  );

  modport slave (
    input  pll_lock_i,
    input  relock_req_i,
    output pll_rst_o,
    output sys_rst_o,
    output ready_o,
    output fault_o,
    output lock_loss_cnt_o
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
// Drives the RESET input of the PLL, qualifies its LOCK output and produces
// the system reset for logic clocked by the PLL output. Loss of lock in RUN
// triggers a full re-lock; a bounded number of failed lock attempts ends in a
// sticky FAULT that only rst clears.
//
// Ports
//   clk   free-running reference clock (not the PLL output)
//   rst   synchronous, active-high reset
//   bus   pll_lock_supervisor_if.slave (lock/relock in, resets/status out)
//
// Configuration
//   PLL_SUP_LOSS_CNT_EN  when defined, lock_loss_cnt_o is a saturating
//                        counter of lock losses in RUN; otherwise it is tied
//                        to zero and no counter registers exist. The state
//                        machine is identical in both builds.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_FILTER  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RST_HOLD     = 256,
  parameter int RETRY_MAX    = 3
) (
  input logic                  clk,
  input logic                  rst,
  pll_lock_supervisor_if.slave bus
);

  // One shared counter must reach the largest of the phase lengths.
  localparam int MAX_A   = (PLL_RST_CYC > LOCK_FILTER) ? PLL_RST_CYC : LOCK_FILTER;
  localparam int MAX_B   = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Terminal counts. The sample that moves WAIT_LOCK into FILTER is the
  // first qualifying lock sample, so FILTER itself needs LOCK_FILTER-1 more.
  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'((LOCK_FILTER >= 2) ? (LOCK_FILTER - 2) : 0);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  localparam logic [3:0]    RTY_LAST  = 4'(RETRY_MAX - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    retry;
  logic [1:0]    sync;
  logic          lk;

  // Synchronized lock; every decision below uses lk, never pll_lock_i.
  assign lk = sync[1];

  // Two-flop synchronizer for the asynchronous PLL LOCK.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], bus.pll_lock_i};
    end
  end

  // Sequencing state machine with registered outputs. Outputs are decoded
  // from the current state, so they follow a state change by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_PLL_RST;
      cnt           <= {CW{1'b0}};
      retry         <= 4'd0;
      bus.pll_rst_o <= 1'b1;
      bus.sys_rst_o <= 1'b1;
      bus.ready_o   <= 1'b0;
      bus.fault_o   <= 1'b0;
    end else begin
      bus.pll_rst_o <= (state == S_PLL_RST) || (state == S_FAULT);
      bus.sys_rst_o <= (state != S_RUN);
      bus.ready_o   <= (state == S_RUN);
      bus.fault_o   <= (state == S_FAULT);

      // A relock request wins over any same-cycle lock drop, so a requested
      // re-sequence is never counted as a loss. FAULT ignores it.
      if (bus.relock_req_i && (state != S_FAULT)) begin
        state <= S_PLL_RST;
        cnt   <= {CW{1'b0}};
        retry <= 4'd0;
      end else begin
        case (state)
          S_PLL_RST: begin
            if (cnt == RST_LAST) begin
              state <= S_WAIT_LOCK;
              cnt   <= {CW{1'b0}};
            end else begin
              cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            end
          end

          S_WAIT_LOCK: begin
            if (lk) begin
              // A one-sample filter is already satisfied by this sample.
              state <= (LOCK_FILTER == 1) ? S_HOLD : S_FILTER;
              retry <= (LOCK_FILTER == 1) ? 4'd0 : retry;
              cnt   <= {CW{1'b0}};
            end else if (cnt == TO_LAST) begin
              cnt <= {CW{1'b0}};
              if (retry == RTY_LAST) begin
                state <= S_FAULT;
                retry <= retry + 4'd1;
              end else begin
                state <= S_PLL_RST;
                retry <= retry + 4'd1;
              end
            end else begin
              cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            end
          end

          S_FILTER: begin
            if (!lk) begin
              // Back to waiting with a fresh timeout budget.
              state <= S_WAIT_LOCK;
              cnt   <= {CW{1'b0}};
            end else if (cnt == FILT_LAST) begin
              state <= S_HOLD;
              cnt   <= {CW{1'b0}};
              retry <= 4'd0;
            end else begin
              cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            end
          end

          S_HOLD: begin
            if (!lk) begin
              state <= S_PLL_RST;
              cnt   <= {CW{1'b0}};
            end else if (cnt == HOLD_LAST) begin
              state <= S_RUN;
              cnt   <= {CW{1'b0}};
            end else begin
              cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            end
          end

          S_RUN: begin
            if (!lk) begin
              state <= S_PLL_RST;
              cnt   <= {CW{1'b0}};
            end else begin
              cnt <= {CW{1'b0}};
            end
          end

          S_FAULT: begin
            state <= S_FAULT;
            cnt   <= {CW{1'b0}};
          end

          default: begin
            state <= S_PLL_RST;
            cnt   <= {CW{1'b0}};
            retry <= 4'd0;
          end
        endcase
      end
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  // Saturating lock-loss counter; a relock request masks the same-cycle drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt <= 8'd0;
    end else if ((state == S_RUN) && !lk && !bus.relock_req_i && (loss_cnt != 8'd255)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end else begin
      loss_cnt <= loss_cnt;
    end
  end

  assign bus.lock_loss_cnt_o = loss_cnt;
`else
  assign bus.lock_loss_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Table-driven vectors and hand sequences for the lock-sequencing corner
// cases, plus randomized lock/relock/reset stimulus compared every cycle
// against a timestamp-based reference model of the supervisor.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int P_RST   = 4;
  localparam int P_FILT  = 8;
  localparam int P_TO    = 100;
  localparam int P_HOLD  = 16;
  localparam int P_RETRY = 3;

`ifdef PLL_SUP_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .PLL_RST_CYC (P_RST),
    .LOCK_FILTER (P_FILT),
    .LOCK_TIMEOUT(P_TO),
    .RST_HOLD    (P_HOLD),
    .RETRY_MAX   (P_RETRY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phases with entry timestamps instead of counters.
  // WAIT_LOCK and FILTER are one "acquire" phase tracked by the length of the
  // current run of synchronized lock samples.
  localparam int M_RST = 0, M_ACQ = 1, M_HOLD = 2, M_RUN = 3, M_FAULT = 4;
  int          now = 0;
  int          ph = M_RST;
  int          ph_start = 0;
  int          run1 = 0;
  int          fails = 0;
  int          loss = 0;
  logic        hist[$];
  logic [11:0] exp_out = 12'h000;

  function automatic logic [7:0] exp_loss8(input int n);
    return LOSS_EN ? 8'((n > 255) ? 255 : n) : 8'd0;
  endfunction

  function automatic void model_step(input logic lkin, input logic rq, input logic r);
    logic       lk;
    logic [3:0] o;
    now++;
    if (r) begin
      ph = M_RST; ph_start = now; run1 = 0; fails = 0; loss = 0;
      hist.delete();
      exp_out = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      return;
    end
    o  = {(ph == M_RST) || (ph == M_FAULT), ph != M_RUN, ph == M_RUN, ph == M_FAULT};
    lk = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
    hist.push_back(lkin);
    if (hist.size() > 3) void'(hist.pop_front());
    if (rq && ph != M_FAULT) begin
      ph = M_RST; ph_start = now; fails = 0; run1 = 0;
    end else begin
      case (ph)
        M_RST: if (now - ph_start == P_RST) begin ph = M_ACQ; ph_start = now; run1 = 0; end
        M_ACQ: begin
          if (lk) begin
            run1++;
            if (run1 == P_FILT) begin ph = M_HOLD; ph_start = now; fails = 0; end
          end else if (run1 > 0) begin
            run1 = 0; ph_start = now;
          end else if (now - ph_start == P_TO) begin
            fails++; ph_start = now;
            ph = (fails == P_RETRY) ? M_FAULT : M_RST;
          end
        end
        M_HOLD: begin
          if (!lk) begin ph = M_RST; ph_start = now; end
          else if (now - ph_start == P_HOLD) begin ph = M_RUN; ph_start = now; end
        end
        M_RUN: if (!lk) begin loss++; ph = M_RST; ph_start = now; end
        default: ;
      endcase
    end
    exp_out = {o, exp_loss8(loss)};
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cycle(input logic lkin, input logic rq, input logic r);
    logic [11:0] got;
    bus.pll_lock_i   = lkin;
    bus.relock_req_i = rq;
    rst              = r;
    @(posedge clk);
    model_step(lkin, rq, r);
    #1;
    got = {bus.pll_rst_o, bus.sys_rst_o, bus.ready_o, bus.fault_o, bus.lock_loss_cnt_o};
    checks++;
    if (got !== exp_out) begin
      errors++;
      $display("FAIL model cyc=%0d got=%03h exp=%03h (pll,sys,rdy,flt,cnt)", now, got, exp_out);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic run_to_ready(input string name);
    for (int i = 0; i < 300 && bus.ready_o !== 1'b1; i++) cycle(1'b1, 1'b0, 1'b0);
    chk(name, {7'd0, bus.ready_o}, 8'd1);
  endtask

  typedef struct {
    logic r; logic lk; logic rq; int n;
    logic e_pll; logic e_sys; logic e_rdy; logic e_flt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Lock rises 10 cycles after pll_rst_o falls.
    tbl.push_back('{1'b1, 1'b0, 1'b0,   2, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,   4, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,   1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,   9, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0,  26, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0,   1, 1'b0, 1'b0, 1'b1, 1'b0});
    // Five-cycle lock glitch, then steady lock.
    tbl.push_back('{1'b1, 1'b0, 1'b0,   2, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,   4, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,   6, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0,   5, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,  10, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0,  26, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0,   1, 1'b0, 1'b0, 1'b1, 1'b0});
    // Lock never arrives: three attempts, then sticky fault.
    tbl.push_back('{1'b1, 1'b0, 1'b0,   2, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,   4, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,   4, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,   4, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1,   1, 1'b1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0,  40, 1'b1, 1'b1, 1'b0, 1'b1});

    bus.pll_lock_i   = 1'b0;
    bus.relock_req_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) cycle(tbl[i].lk, tbl[i].rq, tbl[i].r);
      chk($sformatf("vec%0d_pll_rst", i), {7'd0, bus.pll_rst_o}, {7'd0, tbl[i].e_pll});
      chk($sformatf("vec%0d_sys_rst", i), {7'd0, bus.sys_rst_o}, {7'd0, tbl[i].e_sys});
      chk($sformatf("vec%0d_ready",   i), {7'd0, bus.ready_o},   {7'd0, tbl[i].e_rdy});
      chk($sformatf("vec%0d_fault",   i), {7'd0, bus.fault_o},   {7'd0, tbl[i].e_flt});
    end
    chk("fault_loss_cnt", bus.lock_loss_cnt_o, 8'd0);

    // One-cycle lock drop in RUN.
    cycle(1'b1, 1'b0, 1'b1);
    run_to_ready("ready_before_drop");
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("drop_sys_rst_early", {7'd0, bus.sys_rst_o}, 8'd0);
    chk("drop_loss_cnt", bus.lock_loss_cnt_o, exp_loss8(1));
    cycle(1'b1, 1'b0, 1'b0);
    chk("drop_sys_rst", {7'd0, bus.sys_rst_o}, 8'd1);
    chk("drop_ready", {7'd0, bus.ready_o}, 8'd0);
    run_to_ready("ready_after_drop");

    // Relock request in RUN: four-cycle PLL reset pulse, loss count kept.
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk($sformatf("relock_pll_rst%0d", i), {7'd0, bus.pll_rst_o}, 8'd1);
    end
    cycle(1'b1, 1'b0, 1'b0);
    chk("relock_pll_rst_end", {7'd0, bus.pll_rst_o}, 8'd0);
    chk("relock_loss_cnt", bus.lock_loss_cnt_o, exp_loss8(1));
    run_to_ready("ready_after_relock");

    // Relock on the same cycle as the synchronized lock drop: no loss counted.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("relock_prio_loss_cnt", bus.lock_loss_cnt_o, exp_loss8(1));
    chk("relock_prio_sys_rst", {7'd0, bus.sys_rst_o}, 8'd1);
    run_to_ready("ready_after_prio");

    // 300 more losses: saturation at 255 (or 0 without the counter).
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 300 && bus.ready_o !== 1'b1; i++) cycle(1'b1, 1'b0, 1'b0);
    end
    chk("loss_saturate", bus.lock_loss_cnt_o, exp_loss8(301));

    // Randomized lock runs with sporadic relock and reset.
    begin
      int   left;
      logic lv;
      left = 0;
      lv   = 1'b0;
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5000; i++) begin
        if (left == 0) begin
          lv = ~lv;
          if (lv) left = int'($urandom_range(1, 80));
          else if ($urandom_range(0, 19) == 0) left = int'($urandom_range(100, 350));
          else left = int'($urandom_range(1, 12));
        end
        left--;
        cycle(lv, ($urandom_range(0, 149) == 0), ($urandom_range(0, 1999) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
